// File: rtl/count_pkg.sv
// Shared types and constants for the counter and its downstream consumers.
//   CNT_W     : counter / compare width
//   CMP_NUM   : default number of compare registers
//   IDX_W     : comparator index width
//   evt_t     : logged match event {comparator index, count}
//   lowest_idx: index of the lowest set bit of a comparator vector
package count_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CMP_NUM = 2;
  localparam int unsigned IDX_W   = $clog2(CMP_NUM);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
  } evt_t;

  // Returns 0 when no bit is set; callers qualify with a reduction-or.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [CMP_NUM-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(CMP_NUM) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/count_match_capture_if.sv
// Event stream port of count_match_capture.
//   evt_valid : head entry present
//   evt_ready : consumer accepts the head entry
//   evt_data  : head entry {idx, count}
// master drives valid/data, slave drives ready.
interface count_match_capture_if;
  import count_pkg::*;

  logic evt_valid;
  logic evt_ready;
  evt_t evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full unless popping too)
//   pop        : read request (ignored when empty)
//   dout       : head entry, zero when empty
//   full/empty : occupancy flags
module sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [AW:0] wr_q, rd_q;
  T            mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    dout = '0;
    if (!empty) dout = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/count_match_capture.sv
// Compares a live counter value against programmable compare registers, pulses match_o
// on each rising match and logs the lowest-index event {idx, count} into a FIFO.
//   clk, reset            : clock, synchronous active-high reset
//   count_in, count_vld   : counter value and its qualifier
//   cfg_we/sel/en/data    : compare register write port
//   match_o               : registered one-cycle match pulse per comparator
//   evt                   : event stream (valid/ready/data), master side
//   ovf, ovf_clr          : sticky drop flag and its clear
module count_match_capture
  import count_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_W,
  parameter int unsigned NUM_CMP = CMP_NUM,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       count_vld,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_CMP)-1:0] cfg_sel,
  input  logic                       cfg_en,
  input  logic [WIDTH-1:0]           cfg_data,
  output logic [NUM_CMP-1:0]         match_o,
  count_match_capture_if.master      evt,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  logic [WIDTH-1:0]   cmp_q [NUM_CMP];
  logic [NUM_CMP-1:0] cmp_en_q, match_prev_q, match_q;
  logic [NUM_CMP-1:0] hit, ev;
  logic               ovf_q, ovf_d;
  logic               push, drop, fifo_full, fifo_empty;
  evt_t               push_evt, head_evt;

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_CMP); i++) begin
      hit[i] = count_vld & cmp_en_q[i] & (count_in == cmp_q[i]);
    end
    // Rising edge only, so a held counter logs a single event.
    ev = hit & ~match_prev_q;
  end

  // Only the lowest firing comparator is logged; the rest are not counted as drops.
  assign push         = |ev;
  assign push_evt.idx = lowest_idx(ev);
  assign push_evt.cnt = count_in;
  assign drop         = push & fifo_full & ~evt.evt_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CMP); i++) cmp_q[i] <= '0;
      cmp_en_q     <= '0;
      match_prev_q <= '0;
      match_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      match_prev_q <= hit;
      match_q      <= ev;
      ovf_q        <= ovf_d;
      if (cfg_we) begin
        cmp_q[cfg_sel]        <= cfg_data;
        cmp_en_q[cfg_sel]     <= cfg_en;
        // Forget the old level so rewriting the live count fires again.
        match_prev_q[cfg_sel] <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .T     (evt_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_evt),
    .pop   (evt.evt_ready),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign match_o       = match_q;
  assign ovf           = ovf_q;
  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_data  = head_evt;

endmodule

// File: tb/tb_count_match_capture.sv
module tb_count_match_capture;
  import count_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] count_in = '0;
  logic       count_vld = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_sel = 1'b0;
  logic       cfg_en = 1'b0;
  logic [7:0] cfg_data = '0;
  logic [1:0] match_o;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  count_match_capture_if evt_if ();

  int   checks = 0;
  int   errors = 0;
  evt_t exp_q[$];

  always #5 clk = ~clk;

  count_match_capture #(
    .WIDTH   (8),
    .NUM_CMP (2),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .count_vld (count_vld),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_en    (cfg_en),
    .cfg_data  (cfg_data),
    .match_o   (match_o),
    .evt       (evt_if),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic evt_t mk(input int i, input int c);
    evt_t e;
    e.idx = IDX_W'(i);
    e.cnt = CNT_W'(c);
    return e;
  endfunction

  task automatic step(input logic [7:0] c, input logic v);
    count_in  = c;
    count_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic s, input logic [7:0] d, input logic e);
    cfg_we   = 1'b1;
    cfg_sel  = s;
    cfg_data = d;
    cfg_en   = e;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // Scoreboard monitor: every accepted head entry must match the next expected event.
  always @(negedge clk) begin
    evt_t e;
    if (!reset && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got %0h expected none", evt_if.evt_data);
      end else begin
        e = exp_q.pop_front();
        chk("evt_data", 32'(evt_if.evt_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[4];
    seq = '{8'h20, 8'h30, 8'h20, 8'h30};

    // 1. reset with junk inputs
    evt_if.evt_ready = 1'b1;
    count_in = 8'hA5; count_vld = 1'b1;
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 8'h5A; cfg_en = 1'b1; ovf_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", 32'(match_o), 0);
    chk("rst_valid", 32'(evt_if.evt_valid), 0);
    chk("rst_data", 32'(evt_if.evt_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    reset = 1'b0; cfg_we = 1'b0; ovf_clr = 1'b0; count_vld = 1'b0;
    step(8'h00, 1'b0);

    cfg(1'b0, 8'h05, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c == 5) exp_q.push_back(mk(0, 5));
      step(8'(c), 1'b1);
      chk("t1_match", 32'(match_o), (c == 5) ? 1 : 0);
      if (c == 5) chk("t1_valid", 32'(evt_if.evt_valid), 1);
    end

    // 2. held count logs once; rewriting the compare value re-fires
    exp_q.push_back(mk(0, 5));
    for (int i = 0; i < 10; i++) begin
      step(8'h05, 1'b1);
      chk("t2_hold_match", 32'(match_o), (i == 0) ? 1 : 0);
    end
    cfg(1'b0, 8'h05, 1'b1);
    chk("t2_cfg_match", 32'(match_o), 0);
    exp_q.push_back(mk(0, 5));
    step(8'h05, 1'b1);
    chk("t2_refire", 32'(match_o), 1);
    step(8'h00, 1'b0);

    // 3. simultaneous match: both pulse, only idx 0 logged
    cfg(1'b0, 8'h10, 1'b1);
    cfg(1'b1, 8'h10, 1'b1);
    step(8'h0F, 1'b1);
    exp_q.push_back(mk(0, 8'h10));
    step(8'h10, 1'b1);
    chk("t3_both", 32'(match_o), 3);
    step(8'h11, 1'b1);
    chk("t3_after", 32'(match_o), 0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // 4. fill with no consumer, then overflow
    evt_if.evt_ready = 1'b0;
    cfg(1'b0, 8'h20, 1'b1);
    cfg(1'b1, 8'h30, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk((seq[i] == 8'h30) ? 1 : 0, seq[i]));
      step(8'(seq[i]), 1'b1);
    end
    chk("t4_ovf_full", 32'(ovf), 0);
    chk("t4_valid", 32'(evt_if.evt_valid), 1);
    step(8'h20, 1'b1);
    chk("t4_drop_match", 32'(match_o), 1);
    chk("t4_ovf_set", 32'(ovf), 1);
    ovf_clr = 1'b1;
    step(8'h30, 1'b1);
    chk("t4_ovf_set_prio", 32'(ovf), 1);
    step(8'h00, 1'b1);
    chk("t4_ovf_clr", 32'(ovf), 0);
    ovf_clr = 1'b0;

    // 5. full FIFO, event plus pop in the same cycle
    exp_q.push_back(mk(0, 8'h20));
    evt_if.evt_ready = 1'b1;
    step(8'h20, 1'b1);
    chk("t5_match", 32'(match_o), 1);
    chk("t5_ovf", 32'(ovf), 0);
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0);
    chk("t5_drained", 32'(evt_if.evt_valid), 0);

    // 6. wrap to zero, gated count, reset with queued entries
    cfg(1'b0, 8'h00, 1'b1);
    cfg(1'b1, 8'h00, 1'b0);
    step(8'hFF, 1'b1);
    exp_q.push_back(mk(0, 0));
    step(8'h00, 1'b1);
    chk("t6_wrap", 32'(match_o), 1);
    step(8'h01, 1'b1);
    step(8'h00, 1'b0);
    chk("t6_novld", 32'(match_o), 0);
    step(8'h00, 1'b0);
    chk("t6_novld_valid", 32'(evt_if.evt_valid), 0);

    evt_if.evt_ready = 1'b0;
    cfg(1'b0, 8'h40, 1'b1);
    cfg(1'b1, 8'h41, 1'b1);
    step(8'h40, 1'b1);
    step(8'h41, 1'b1);
    step(8'h40, 1'b1);
    chk("t6_queued", 32'(evt_if.evt_valid), 1);
    reset = 1'b1;
    step(8'h00, 1'b0);
    chk("t6_rst_valid", 32'(evt_if.evt_valid), 0);
    chk("t6_rst_data", 32'(evt_if.evt_data), 0);
    chk("t6_rst_match", 32'(match_o), 0);
    reset = 1'b0;
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0);
    chk("t6_post_rst", 32'(evt_if.evt_valid), 0);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
